// File: rtl/morse_char_decoder.sv
// Morse letter assembler: collects dot/dash pulses, decodes letters to ASCII, inserts word spaces, FWFT output FIFO.
// Optional macro MORSE_PUNCT_EN widens the accumulator to 6 symbols and adds . , ? / decodes.
module morse_char_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_SYM    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dot_in,
    input  logic       dash_in,
    input  logic       lg_in,
    input  logic       wg_in,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       decode_err,
    output logic       fifo_ovf
);
`ifdef MORSE_PUNCT_EN
    localparam int CAP = 6;
`else
    localparam int CAP = MAX_SYM;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] CAP_C = 3'(CAP);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    // returns {err, ascii}; pat holds the symbols right-aligned, first symbol most significant
    function automatic logic [8:0] decode(input logic [2:0] cnt, input logic [7:0] pat);
        logic [8:0] r;
        r = {1'b0, 8'h3F};
        case ({cnt, pat})
            {3'd1, 8'b0}:     r[7:0] = 8'h45;
            {3'd1, 8'b1}:     r[7:0] = 8'h54;
            {3'd2, 8'b00}:    r[7:0] = 8'h49;
            {3'd2, 8'b01}:    r[7:0] = 8'h41;
            {3'd2, 8'b10}:    r[7:0] = 8'h4E;
            {3'd2, 8'b11}:    r[7:0] = 8'h4D;
            {3'd3, 8'b000}:   r[7:0] = 8'h53;
            {3'd3, 8'b001}:   r[7:0] = 8'h55;
            {3'd3, 8'b010}:   r[7:0] = 8'h52;
            {3'd3, 8'b011}:   r[7:0] = 8'h57;
            {3'd3, 8'b100}:   r[7:0] = 8'h44;
            {3'd3, 8'b101}:   r[7:0] = 8'h4B;
            {3'd3, 8'b110}:   r[7:0] = 8'h47;
            {3'd3, 8'b111}:   r[7:0] = 8'h4F;
            {3'd4, 8'b0000}:  r[7:0] = 8'h48;
            {3'd4, 8'b0001}:  r[7:0] = 8'h56;
            {3'd4, 8'b0010}:  r[7:0] = 8'h46;
            {3'd4, 8'b0100}:  r[7:0] = 8'h4C;
            {3'd4, 8'b0110}:  r[7:0] = 8'h50;
            {3'd4, 8'b0111}:  r[7:0] = 8'h4A;
            {3'd4, 8'b1000}:  r[7:0] = 8'h42;
            {3'd4, 8'b1001}:  r[7:0] = 8'h58;
            {3'd4, 8'b1010}:  r[7:0] = 8'h43;
            {3'd4, 8'b1011}:  r[7:0] = 8'h59;
            {3'd4, 8'b1100}:  r[7:0] = 8'h5A;
            {3'd4, 8'b1101}:  r[7:0] = 8'h51;
            {3'd5, 8'b00000}: r[7:0] = 8'h35;
            {3'd5, 8'b00001}: r[7:0] = 8'h34;
            {3'd5, 8'b00011}: r[7:0] = 8'h33;
            {3'd5, 8'b00111}: r[7:0] = 8'h32;
            {3'd5, 8'b01111}: r[7:0] = 8'h31;
            {3'd5, 8'b11111}: r[7:0] = 8'h30;
            {3'd5, 8'b10000}: r[7:0] = 8'h36;
            {3'd5, 8'b11000}: r[7:0] = 8'h37;
            {3'd5, 8'b11100}: r[7:0] = 8'h38;
            {3'd5, 8'b11110}: r[7:0] = 8'h39;
`ifdef MORSE_PUNCT_EN
            {3'd5, 8'b10010}:  r[7:0] = 8'h2F;
            {3'd6, 8'b010101}: r[7:0] = 8'h2E;
            {3'd6, 8'b110011}: r[7:0] = 8'h2C;
            {3'd6, 8'b001100}: r[7:0] = 8'h3F;
`endif
            default:          r = {1'b1, 8'h3F};
        endcase
        return r;
    endfunction

    logic [CAP-1:0] sym_reg_q, sym_reg_d, acc_reg;
    logic [2:0]     sym_cnt_q, sym_cnt_d, acc_cnt;
    logic           ovr_q, ovr_d, acc_ovr;
    logic           inv_q, inv_d, acc_inv;
    logic           pend_space_q, pend_space_d;
    logic           last_space_q, last_space_d;
    logic           decode_err_q, decode_err_d;
    logic           fifo_ovf_q, fifo_ovf_d;
    logic [7:0]     dec_ch, push_char;
    logic           dec_err, push, close;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    fifo_cnt_q, fifo_cnt_d;
    logic           full, pop, push_ok;

    always_comb begin
        acc_reg = sym_reg_q;
        acc_cnt = sym_cnt_q;
        acc_ovr = ovr_q;
        acc_inv = inv_q;
        if (dot_in | dash_in) begin
            if (dot_in & dash_in) acc_inv = 1'b1;
            if (sym_cnt_q == CAP_C) begin
                acc_ovr = 1'b1;
            end else begin
                acc_reg = {sym_reg_q[CAP-2:0], dash_in & ~dot_in};
                acc_cnt = sym_cnt_q + 3'd1;
            end
        end
        {dec_err, dec_ch} = decode(acc_cnt, 8'(acc_reg));
        if (acc_ovr | acc_inv) begin
            dec_err = 1'b1;
            dec_ch  = 8'h3F;
        end

        close        = lg_in | wg_in;
        sym_reg_d    = acc_reg;
        sym_cnt_d    = acc_cnt;
        ovr_d        = acc_ovr;
        inv_d        = acc_inv;
        pend_space_d = pend_space_q;
        last_space_d = last_space_q;
        push         = 1'b0;
        push_char    = 8'h00;
        decode_err_d = 1'b0;
        if (close) begin
            sym_reg_d = '0;
            sym_cnt_d = '0;
            ovr_d     = 1'b0;
            inv_d     = 1'b0;
        end
        // a letter push takes the single write slot; a pending space follows one edge later
        if (close && acc_cnt != 3'd0) begin
            push         = 1'b1;
            push_char    = dec_ch;
            decode_err_d = dec_err;
            last_space_d = 1'b0;
            if (wg_in) pend_space_d = 1'b1;
        end else if (pend_space_q | wg_in) begin
            pend_space_d = 1'b0;
            if (!last_space_q) begin
                push         = 1'b1;
                push_char    = 8'h20;
                last_space_d = 1'b1;
            end
        end
    end

    always_comb begin
        full       = (fifo_cnt_q == DEPTH_C);
        pop        = char_valid & char_ready;
        push_ok    = push & (~full | pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push_ok & ~pop) fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
        else if (~push_ok & pop) fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
        fifo_ovf_d = fifo_ovf_q | (push & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sym_reg_q    <= '0;
            sym_cnt_q    <= '0;
            ovr_q        <= 1'b0;
            inv_q        <= 1'b0;
            pend_space_q <= 1'b0;
            last_space_q <= 1'b1;
            decode_err_q <= 1'b0;
            fifo_ovf_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
        end else begin
            sym_reg_q    <= sym_reg_d;
            sym_cnt_q    <= sym_cnt_d;
            ovr_q        <= ovr_d;
            inv_q        <= inv_d;
            pend_space_q <= pend_space_d;
            last_space_q <= last_space_d;
            decode_err_q <= decode_err_d;
            fifo_ovf_q   <= fifo_ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end

    // storage needs no reset: entries are only visible while counted as valid
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) mem_q[wr_ptr_q] <= push_char;
    end

    assign char_valid = (fifo_cnt_q != '0);
    assign char_out   = char_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign decode_err = decode_err_q;
    assign fifo_ovf   = fifo_ovf_q;
endmodule

// File: tb/tb_morse_char_decoder.sv
// Directed bench for morse_char_decoder: letters, spaces, overflow paths and mid-letter reset.
module tb_morse_char_decoder;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dot_in = 1'b0, dash_in = 1'b0, lg_in = 1'b0, wg_in = 1'b0;
    logic       char_ready = 1'b0;
    logic [7:0] char_out;
    logic       char_valid, decode_err, fifo_ovf;
    int         checks = 0;
    int         errors = 0;

    morse_char_decoder #(.FIFO_DEPTH(4), .MAX_SYM(5)) dut (
        .clk(clk), .reset_n(reset_n), .dot_in(dot_in), .dash_in(dash_in),
        .lg_in(lg_in), .wg_in(wg_in), .char_out(char_out), .char_valid(char_valid),
        .char_ready(char_ready), .decode_err(decode_err), .fifo_ovf(fifo_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic d, input logic da, input logic l, input logic w);
        dot_in = d; dash_in = da; lg_in = l; wg_in = w;
        tick();
        dot_in = 1'b0; dash_in = 1'b0; lg_in = 1'b0; wg_in = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(); tick();
        chk("rst_valid", {7'b0, char_valid}, 8'h00);
        chk("rst_out", char_out, 8'h00);
        chk("rst_err", {7'b0, decode_err}, 8'h00);
        chk("rst_ovf", {7'b0, fifo_ovf}, 8'h00);
        reset_n = 1'b1;
        char_ready = 1'b1;
        tick();

        pulse(0, 0, 0, 1);
        chk("lead_wg_valid", {7'b0, char_valid}, 8'h00);
        tick();
        chk("lead_wg_valid2", {7'b0, char_valid}, 8'h00);

        // A: .-
        pulse(1, 0, 0, 0); pulse(0, 1, 0, 0);
        chk("a_valid_pre", {7'b0, char_valid}, 8'h00);
        pulse(0, 0, 1, 0);
        chk("a_valid", {7'b0, char_valid}, 8'h01);
        chk("a_char", char_out, 8'h41);
        chk("a_err", {7'b0, decode_err}, 8'h00);
        tick();
        chk("a_one_cycle", {7'b0, char_valid}, 8'h00);

        // S, word gap, repeated word gap, O
        pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        chk("s_char", char_out, 8'h53);
        pulse(0, 0, 0, 1);
        chk("space_valid", {7'b0, char_valid}, 8'h01);
        chk("space_char", char_out, 8'h20);
        tick();
        chk("no_dup_space", {7'b0, char_valid}, 8'h00);
        tick();
        chk("no_dup_space2", {7'b0, char_valid}, 8'h00);
        pulse(0, 1, 0, 0); pulse(0, 1, 0, 0); pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        chk("o_char", char_out, 8'h4F);
        tick();

        // six dots overflow, then digit 1
        for (int i = 0; i < 6; i++) pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        chk("ovr_char", char_out, 8'h3F);
        chk("ovr_err", {7'b0, decode_err}, 8'h01);
        tick();
        chk("ovr_err_pulse", {7'b0, decode_err}, 8'h00);
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        chk("one_char", char_out, 8'h31);
        chk("one_err", {7'b0, decode_err}, 8'h00);
        tick();

        // FIFO fill with consumer stalled: E T I A held, M dropped
        char_ready = 1'b0;
        pulse(1, 0, 1, 0);
        pulse(0, 1, 1, 0);
        pulse(1, 0, 0, 0); pulse(1, 0, 1, 0);
        pulse(1, 0, 0, 0); pulse(0, 1, 1, 0);
        chk("full_head", char_out, 8'h45);
        chk("full_no_ovf", {7'b0, fifo_ovf}, 8'h00);
        pulse(0, 1, 0, 0); pulse(0, 1, 1, 0);
        chk("ovf_set", {7'b0, fifo_ovf}, 8'h01);
        chk("hold_head", char_out, 8'h45);
        tick();
        chk("ovf_sticky", {7'b0, fifo_ovf}, 8'h01);
        char_ready = 1'b1;
        chk("drain0", char_out, 8'h45);
        tick();
        chk("drain1", char_out, 8'h54);
        tick();
        chk("drain2", char_out, 8'h49);
        tick();
        chk("drain3", char_out, 8'h41);
        tick();
        chk("drained", {7'b0, char_valid}, 8'h00);
        chk("ovf_still", {7'b0, fifo_ovf}, 8'h01);

        // dash with the gap appends first; dot+dash together is invalid
        pulse(1, 0, 0, 0);
        pulse(0, 1, 1, 0);
        chk("gap_sym_char", char_out, 8'h41);
        chk("gap_sym_err", {7'b0, decode_err}, 8'h00);
        tick();
        pulse(1, 1, 0, 0);
        pulse(0, 0, 1, 0);
        chk("both_char", char_out, 8'h3F);
        chk("both_err", {7'b0, decode_err}, 8'h01);
        tick();

        // reset mid-letter with two queued entries
        char_ready = 1'b0;
        pulse(1, 0, 1, 0);
        pulse(0, 1, 1, 0);
        pulse(0, 1, 0, 0); pulse(0, 1, 0, 0);
        chk("pre_rst_valid", {7'b0, char_valid}, 8'h01);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_mid_valid", {7'b0, char_valid}, 8'h00);
        chk("rst_mid_ovf", {7'b0, fifo_ovf}, 8'h00);
        char_ready = 1'b1;
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        chk("post_rst_char", char_out, 8'h45);
        chk("post_rst_valid", {7'b0, char_valid}, 8'h01);
        tick();
        chk("post_rst_only", {7'b0, char_valid}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/morse_char_decoder.md
Name: morse_char_decoder

Overview:
- Downstream stage of the Morse keying FSM: consumes its one-cycle dot/dash/letter-gap/word-gap pulses and assembles symbols into letters.
- Decodes each letter to 8-bit ASCII and emits a space on a word gap.
- Characters leave through a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake, feeding a display or UART stage.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries (power of 2, at least 2).
- MAX_SYM, 5, max symbols per letter; covers A-Z and 0-9.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- dot_in  in  1  one-cycle pulse, dot completed
- dash_in  in  1  one-cycle pulse, dash completed
- lg_in  in  1  one-cycle pulse, letter gap
- wg_in  in  1  one-cycle pulse, word gap
- char_out  out  8  ASCII code at FIFO head
- char_valid  out  1  FIFO non-empty
- char_ready  in  1  consumer accepts head when char_valid high
- decode_err  out  1  one-cycle pulse when '?' is pushed for an invalid letter
- fifo_ovf  out  1  sticky, a character was dropped because the FIFO was full

Behaviour:
- One clock, clk. Reset is synchronous and active-low (reset_n sampled on the rising clk edge).
- Reset state: all outputs 0, FIFO empty, sym_cnt=0, sym_reg=0, pend_space=0, last_space=1.
- Reset mid-operation discards the partial letter and all FIFO contents.
- Accumulator:
  - sym_reg[MAX_SYM-1:0] stores one bit per symbol (1=dash, 0=dot); the first symbol is the MSB of the used field. sym_cnt is 3 bits.
  - dot_in or dash_in shifts the symbol in and increments sym_cnt.
  - dot_in and dash_in both high in one cycle: record one invalid symbol; the letter decodes to '?'.
  - Symbol at sym_cnt==MAX_SYM: set internal ovr flag, sym_cnt saturates; the letter decodes to '?'.
- Letter close, on lg_in or wg_in:
  - If sym_cnt>0: decode and push the character at the next edge (gap pulse at cycle N gives the push at edge N+1; char_valid high in cycle N+1 if the FIFO was empty).
  - Then clear sym_cnt, sym_reg, ovr, last_space=0.
  - A symbol pulse in the same cycle as a gap is appended before the close.
  - lg_in and wg_in together are treated as wg_in.
- Decode table:
  - A-Z map to 0x41-0x5A using standard ITU patterns (e.g. .-=0x41, -...=0x42, ...=0x53, ---=0x4F).
  - 0-9 map to 0x30-0x39 (-----=0x30, .----=0x31, ....-=0x34).
  - Any other pattern, or ovr, gives 0x3F '?' with decode_err high for one cycle at the push.
- Word gap:
  - wg_in sets pend_space; the space 0x20 is pushed one cycle after any letter push (edge N+2), or at N+1 if no letter was pending.
  - No space is pushed if last_space=1 (suppresses duplicate and leading spaces). A pushed space sets last_space=1.
- FIFO:
  - FWFT: char_out shows the head whenever char_valid=1.
  - A pop occurs when char_valid&char_ready.
  - Push and pop in the same cycle when full is allowed; the push succeeds.
  - Push when full and no pop: the character is dropped, fifo_ovf set until reset, and FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the count has log2(FIFO_DEPTH)+1 bits.
- char_out holds its value while char_valid=1 and char_ready=0.

Optional Feature:
- MORSE_PUNCT_EN.
- When defined:
  - Internal capacity is 6 symbols.
  - Added decodes: .-.-.-=0x2E '.', --..--=0x2C ',', ..--..=0x3F '?' (decode_err stays 0 for this valid '?'), -..-.=0x2F '/'.
  - The 7th symbol sets ovr.
- When undefined:
  - Capacity is MAX_SYM.
  - These patterns decode to '?' with decode_err (the 6-symbol ones via ovr).

Test Plan:
- dot, dash, lg, char_ready=1 -> char_out=0x41 with char_valid high exactly 1 cycle, at the edge after lg; decode_err=0.
- dot,dot,dot, wg, then dash,dash,dash, lg -> stream 0x53, 0x20, 0x4F; a second wg immediately after gives no extra space; wg straight after reset gives no output.
- Six dots, lg (macro undefined) -> 0x3F, decode_err pulse; .---- lg -> 0x31.
- char_ready=0, five letters closed (FIFO_DEPTH=4) -> first four held in order, fifth dropped, fifo_ovf=1 and stays 1; raise char_ready -> four entries drain, then char_valid=0.
- dash pulse in the same cycle as lg after a dot -> decodes .- = 0x41; dot_in and dash_in in the same cycle then lg -> 0x3F.
- reset_n low for 1 cycle mid-letter (after dash,dash) with 2 FIFO entries -> char_valid=0; a following dot, lg -> 0x45 only.
